// File: rtl/psg_command_encoder.sv
// Command encoder for the SN76489 register-write bus: buffers tone/attenuation/noise/raw
// commands in a FIFO and serialises them into held latch/data bytes.
module psg_command_encoder #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_chan,
  input  logic [9:0] cmd_value,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       cmd_error
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLatch, StData} state_e;

  state_e           state_q;
  logic [13:0]      fifo_mem [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic [HoldW-1:0] hold_cnt_q;
  logic [7:0]       data_byte_q;
  logic             is_tone_q;

  logic             accept, reject, push, pop, fifo_empty, hold_done, cmd_done, busy_d;
  logic [13:0]      head;
  logic [7:0]       head_latch, head_data;
  logic [HoldW-1:0] latch_hold;

  assign cmd_ready  = (count_q != (AddrW + 1)'(FIFO_DEPTH));
  assign accept     = cmd_valid & cmd_ready;
  assign reject     = accept & (cmd_type == 2'd0) & (cmd_chan == 2'd3);
  assign push       = accept & ~reject;
  assign fifo_empty = (count_q == '0);

  assign hold_done = (hold_cnt_q == '0);
  assign cmd_done  = hold_done & (((state_q == StLatch) & ~is_tone_q) | (state_q == StData));
  assign pop       = ~fifo_empty & ((state_q == StIdle) | cmd_done);
  assign count_d   = count_q + (AddrW + 1)'(push) - (AddrW + 1)'(pop);
  assign busy_d    = pop | ((state_q != StIdle) & ~cmd_done) | (count_d != '0);

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    head_latch = head[7:0];
    unique case (head[13:12])
      2'd0:    head_latch = {1'b1, head[11:10], 1'b0, head[3:0]};
      2'd1:    head_latch = {1'b1, head[11:10], 1'b1, head[3:0]};
      2'd2:    head_latch = {5'b11100, head[2:0]};
      default: head_latch = head[7:0];
    endcase
    head_data  = {2'b00, head[9:4]};
    // Noise-class bytes retrigger the noise generator, so they are never held.
    latch_hold = (head_latch[7:4] == 4'hE) ? '0 : HoldReload;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_type, cmd_chan, cmd_value};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_cnt_q  <= '0;
      data_byte_q <= 8'h00;
      is_tone_q   <= 1'b0;
      data_out    <= 8'h00;
      busy        <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      cmd_error <= reject;
      busy      <= busy_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + AddrW'(1);
        state_q     <= StLatch;
        data_out    <= head_latch;
        data_byte_q <= head_data;
        is_tone_q   <= (head[13:12] == 2'd0);
        hold_cnt_q  <= latch_hold;
      end else begin
        unique case (state_q)
          StIdle: ;
          StLatch: begin
            if (!hold_done) begin
              hold_cnt_q <= hold_cnt_q - HoldW'(1);
            end else if (is_tone_q) begin
              state_q    <= StData;
              data_out   <= data_byte_q;
              hold_cnt_q <= HoldReload;
            end else begin
              state_q <= StIdle;
              // Noise latch stays selected; 0x00 is then a harmless non-latch byte.
              if (data_out[7:4] == 4'hE) data_out <= 8'h00;
            end
          end
          StData: begin
            if (!hold_done) begin
              hold_cnt_q <= hold_cnt_q - HoldW'(1);
            end else begin
              state_q <= StIdle;
              if (data_out[7:4] == 4'hE) data_out <= 8'h00;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psg_command_encoder.sv
// Bench for psg_command_encoder: two instances (HOLD 2 and HOLD 4) against a byte-stream model.
module tb_psg_command_encoder;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [1:0] cmd_chan = 2'd0;
  logic [9:0] cmd_value = 10'd0;
  logic [7:0] dout [2];
  logic       rdy  [2];
  logic       bsy  [2];
  logic       err  [2];

  psg_command_encoder #(.HOLD_CYCLES(2), .FIFO_DEPTH(Depth)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_type(cmd_type), .cmd_chan(cmd_chan), .cmd_value(cmd_value),
    .data_out(dout[0]), .busy(bsy[0]), .cmd_error(err[0])
  );

  psg_command_encoder #(.HOLD_CYCLES(4), .FIFO_DEPTH(Depth)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_type(cmd_type), .cmd_chan(cmd_chan), .cmd_value(cmd_value),
    .data_out(dout[1]), .busy(bsy[1]), .cmd_error(err[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queue of accepted commands, and queue of (byte, clocks left) still to appear on the bus.
  typedef struct {
    logic [7:0] b;
    int         n;
  } seg_t;

  seg_t       segq [2][$];
  logic [13:0] mq  [2][$];
  logic [7:0] m_out [2];
  bit         m_busy [2];
  bit         m_err [2];

  function automatic int hold_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expand(int i, logic [13:0] c);
    logic [1:0] t;
    logic [1:0] ch;
    logic [9:0] v;
    seg_t       s;
    t  = c[13:12];
    ch = c[11:10];
    v  = c[9:0];
    case (t)
      2'd0:    s.b = {1'b1, ch, 1'b0, v[3:0]};
      2'd1:    s.b = {1'b1, ch, 1'b1, v[3:0]};
      2'd2:    s.b = 8'hE0 + {5'd0, v[2:0]};
      default: s.b = v[7:0];
    endcase
    s.n = (s.b[7:4] == 4'hE) ? 1 : hold_of(i);
    segq[i].push_back(s);
    if (t == 2'd0) begin
      s.b = {2'b00, v[9:4]};
      s.n = hold_of(i);
      segq[i].push_back(s);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit   acc;
      bit   rej;
      seg_t s;
      acc = cmd_valid && (mq[i].size() < Depth);
      rej = acc && (cmd_type == 2'd0) && (cmd_chan == 2'd3);
      if (reset) begin
        segq[i].delete();
        mq[i].delete();
        m_out[i]  = 8'h00;
        m_err[i]  = 1'b0;
        m_busy[i] = 1'b0;
      end else begin
        m_err[i] = rej;
        if (segq[i].size() > 0) begin
          s = segq[i].pop_front();
          s.n--;
          if (s.n > 0) segq[i].push_front(s);
        end
        if (segq[i].size() == 0 && mq[i].size() > 0) expand(i, mq[i].pop_front());
        if (segq[i].size() > 0) m_out[i] = segq[i][0].b;
        else if (m_out[i][7:4] == 4'hE) m_out[i] = 8'h00;
        if (acc && !rej) mq[i].push_back({cmd_type, cmd_chan, cmd_value});
        m_busy[i] = (segq[i].size() > 0) || (mq[i].size() > 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("data_out%0d", i), 32'(dout[i]), 32'(m_out[i]));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i]));
      check($sformatf("cmd_error%0d", i), 32'(err[i]), 32'(m_err[i]));
      check($sformatf("cmd_ready%0d", i), 32'(rdy[i]), 32'(mq[i].size() < Depth));
    end
  endtask

  task automatic drive(logic [1:0] t, logic [1:0] c, logic [9:0] v);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_chan  = c;
    cmd_value = v;
  endtask

  task automatic send(logic [1:0] t, logic [1:0] c, logic [9:0] v);
    drive(t, c, v);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  initial begin
    bit saw_full;
    int k;
    int guard;

    reset = 1'b1;
    idle(3);
    check("reset_dout", 32'(dout[0]), 32'h00);
    check("reset_busy", 32'(bsy[0]), 32'h0);
    check("reset_ready", 32'(rdy[0]), 32'h1);
    reset = 1'b0;
    idle(2);

    // Tone ch1 0x2A5, HOLD 2 instance.
    send(2'd0, 2'd1, 10'h2A5);
    tick(); check("tone_latch_a", 32'(dout[0]), 32'hA5);
    tick(); check("tone_latch_b", 32'(dout[0]), 32'hA5);
    tick(); check("tone_data_a", 32'(dout[0]), 32'h2A);
    tick(); check("tone_data_b", 32'(dout[0]), 32'h2A);
    check("tone_busy_hi", 32'(bsy[0]), 32'h1);
    tick(); check("tone_idle", 32'(dout[0]), 32'h2A);
    check("tone_busy_lo", 32'(bsy[0]), 32'h0);
    idle(12);

    // Attenuation ch3 0x7 then noise 5.
    send(2'd1, 2'd3, 10'h007);
    send(2'd2, 2'd0, 10'h005);
    check("att_a", 32'(dout[0]), 32'hF7);
    tick(); check("att_b", 32'(dout[0]), 32'hF7);
    tick(); check("noise", 32'(dout[0]), 32'hE5);
    tick(); check("noise_idle_a", 32'(dout[0]), 32'h00);
    tick(); check("noise_idle_b", 32'(dout[0]), 32'h00);
    idle(12);

    // Rejected tone on channel 3.
    send(2'd0, 2'd3, 10'h123);
    check("reject_err", 32'(err[0]), 32'h1);
    check("reject_dout", 32'(dout[0]), 32'h00);
    check("reject_ready", 32'(rdy[0]), 32'h1);
    tick();
    check("reject_err_lo", 32'(err[0]), 32'h0);
    check("reject_busy", 32'(bsy[0]), 32'h0);
    idle(3);

    // Six attenuation commands with valid held, paced by the HOLD 4 instance.
    saw_full = 1'b0;
    k = 0;
    guard = 0;
    while (k < 6 && guard < 200) begin
      bit r;
      r = (mq[1].size() < Depth);
      drive(2'd1, 2'(k), 10'(k));
      tick();
      if (!rdy[1]) saw_full = 1'b1;
      if (guard == 1) check("hold4_first", 32'(dout[1]), 32'h90);
      if (r) k++;
      guard++;
    end
    cmd_valid = 1'b0;
    check("six_accepted", 32'(k), 32'd6);
    check("ready_dropped", 32'(saw_full), 32'h1);
    idle(40);

    // Raw bytes, including a noise-class raw byte.
    send(2'd3, 2'd0, 10'h08F);
    send(2'd3, 2'd0, 10'h03F);
    check("raw_8f", 32'(dout[0]), 32'h8F);
    tick();
    tick(); check("raw_3f", 32'(dout[0]), 32'h3F);
    idle(12);
    send(2'd3, 2'd0, 10'h0E3);
    tick(); check("raw_e3", 32'(dout[0]), 32'hE3);
    tick(); check("raw_e3_idle", 32'(dout[0]), 32'h00);
    idle(12);

    // Reset during the data byte of a tone with two commands queued.
    send(2'd0, 2'd0, 10'h155);
    send(2'd1, 2'd1, 10'h003);
    send(2'd1, 2'd2, 10'h004);
    tick(); check("pre_reset_data", 32'(dout[0]), 32'h15);
    reset = 1'b1;
    tick();
    check("rst_dout", 32'(dout[0]), 32'h00);
    check("rst_busy", 32'(bsy[0]), 32'h0);
    check("rst_ready", 32'(rdy[0]), 32'h1);
    reset = 1'b0;
    idle(20);
    check("post_rst_dout0", 32'(dout[0]), 32'h00);
    check("post_rst_dout1", 32'(dout[1]), 32'h00);

    // Random traffic with occasional resets.
    repeat (3000) begin
      reset     = ($urandom_range(0, 199) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_type  = 2'($urandom_range(0, 3));
      cmd_chan  = 2'($urandom_range(0, 3));
      cmd_value = 10'($urandom_range(0, 1023));
      tick();
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
